// File: rtl/bcd_adder.sv
// rtl/bcd_adder.sv - registered multi-digit packed-BCD adder; optional err output under BCD_ADDER_ERR_EN
module bcd_adder #(
    parameter int DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
`ifdef BCD_ADDER_ERR_EN
    output logic                  err,
`endif
    output logic                  out_valid
);

    logic [4*DIGITS-1:0] r_sum;
    logic                r_cout;
    logic                r_out_valid;
    logic [4*DIGITS-1:0] w_sum;
    logic                w_cout;
    logic                w_carry;
    logic [4:0]          w_raw;

    // Ripple decimal carry digit by digit; digits above 9 use the same +6 correction
    always_comb begin
        w_sum   = '0;
        w_carry = cin;
        w_raw   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_raw = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, w_carry};
            if (w_raw > 5'd9) begin
                w_sum[4*i +: 4] = w_raw[3:0] + 4'd6;
                w_carry         = 1'b1;
            end else begin
                w_sum[4*i +: 4] = w_raw[3:0];
                w_carry         = 1'b0;
            end
        end
        w_cout = w_carry;
    end

    // Capture the result on in_valid; otherwise hold the sum and drop the valid flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
            end
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign out_valid = r_out_valid;

`ifdef BCD_ADDER_ERR_EN
    logic r_err;
    logic w_err;

    // Flag any operand digit outside 0..9
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                w_err = 1'b1;
            end
        end
    end

    // Register the error flag alongside the sum
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (in_valid) begin
            r_err <= w_err;
        end
    end

    assign err = r_err;
`endif

endmodule

// File: tb/tb_bcd_adder.sv
// tb/tb_bcd_adder.sv - directed self-checking bench for bcd_adder (1 and 4 digit instances)
module tb_bcd_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid1;
    logic [3:0]  a1, b1;
    logic        cin1;
    logic [3:0]  sum1;
    logic        cout1;
    logic        out_valid1;
    logic        in_valid4;
    logic [15:0] a4, b4;
    logic        cin4;
    logic [15:0] sum4;
    logic        cout4;
    logic        out_valid4;
`ifdef BCD_ADDER_ERR_EN
    logic        err1;
    logic        err4;
`endif

    int checks = 0;
    int errors = 0;

    bcd_adder #(.DIGITS(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .sum       (sum1),
        .cout      (cout1),
`ifdef BCD_ADDER_ERR_EN
        .err       (err1),
`endif
        .out_valid (out_valid1)
    );

    bcd_adder #(.DIGITS(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .sum       (sum4),
        .cout      (cout4),
`ifdef BCD_ADDER_ERR_EN
        .err       (err4),
`endif
        .out_valid (out_valid4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid1 = 1'b1; a1 = 4'd9; b1 = 4'd9; cin1 = 1'b0;
        in_valid4 = 1'b1; a4 = 16'h9999; b4 = 16'h9999; cin4 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (sum1 !== 4'd0 || cout1 !== 1'b0 || out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL reset1 cyc%0d got sum=%h cout=%b ov=%b want 0 0 0", c, sum1, cout1, out_valid1);
            end
            checks++;
            if (sum4 !== 16'h0 || cout4 !== 1'b0 || out_valid4 !== 1'b0) begin
                errors++;
                $display("FAIL reset4 cyc%0d got sum=%h cout=%b ov=%b want 0 0 0", c, sum4, cout4, out_valid4);
            end
`ifdef BCD_ADDER_ERR_EN
            checks++;
            if (err1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_err got %b want 0", err1);
            end
`endif
        end
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    // vector: {a, b, cin, sum, cout}
    task automatic run_vectors1(input string name, input logic [13:0] v [], input logic back_to_back);
        for (int i = 0; i < v.size(); i++) begin
            a1 = v[i][13:10]; b1 = v[i][9:6]; cin1 = v[i][5]; in_valid1 = 1'b1;
            tick();
            checks++;
            if (sum1 !== v[i][4:1] || cout1 !== v[i][0] || out_valid1 !== 1'b1) begin
                errors++;
                $display("FAIL %s[%0d] got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=1",
                         name, i, sum1, cout1, out_valid1, v[i][4:1], v[i][0]);
            end
            if (!back_to_back) begin
                in_valid1 = 1'b0;
                tick();
            end
        end
        in_valid1 = 1'b0;
    endtask

    task automatic test_single();
        logic [13:0] v [];
        v = new[4];
        v[0] = {4'b0111, 4'b0101, 1'b0, 4'b0010, 1'b1};
        v[1] = {4'b0001, 4'b0001, 1'b1, 4'b0011, 1'b0};
        v[2] = {4'b0001, 4'b0001, 1'b0, 4'b0010, 1'b0};
        v[3] = {4'b1000, 4'b1000, 1'b0, 4'b0110, 1'b1};
        run_vectors1("single", v, 1'b0);
    endtask

    task automatic test_boundary();
        logic [13:0] v [];
        v = new[4];
        v[0] = {4'd9, 4'd0, 1'b0, 4'd9, 1'b0};
        v[1] = {4'd9, 4'd0, 1'b1, 4'd0, 1'b1};
        v[2] = {4'd9, 4'd9, 1'b1, 4'd9, 1'b1};
        v[3] = {4'hF, 4'hF, 1'b1, 4'd5, 1'b1};
        run_vectors1("boundary", v, 1'b0);
    endtask

    task automatic test_ripple();
        logic [15:0] ea [2];
        logic [15:0] eb [2];
        logic        ec [2];
        logic [15:0] es [2];
        logic        eo [2];
        ea = '{16'h9999, 16'h1234}; eb = '{16'h0000, 16'h5678}; ec = '{1'b1, 1'b0};
        es = '{16'h0000, 16'h6912}; eo = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            a4 = ea[i]; b4 = eb[i]; cin4 = ec[i]; in_valid4 = 1'b1;
            tick();
            checks++;
            if (sum4 !== es[i] || cout4 !== eo[i] || out_valid4 !== 1'b1) begin
                errors++;
                $display("FAIL ripple[%0d] got sum=%h cout=%b ov=%b want sum=%h cout=%b ov=1",
                         i, sum4, cout4, out_valid4, es[i], eo[i]);
            end
        end
        in_valid4 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [13:0] v [];
        v = new[5];
        v[0] = {4'd2, 4'd3, 1'b0, 4'd5, 1'b0};
        v[1] = {4'd4, 4'd6, 1'b0, 4'd0, 1'b1};
        v[2] = {4'd5, 4'd5, 1'b1, 4'd1, 1'b1};
        v[3] = {4'd0, 4'd0, 1'b1, 4'd1, 1'b0};
        v[4] = {4'd7, 4'd5, 1'b0, 4'd2, 1'b1};
        run_vectors1("b2b", v, 1'b1);
    endtask

    task automatic test_hold();
        in_valid1 = 1'b0; a1 = 4'd3; b1 = 4'd3; cin1 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (sum1 !== 4'd2 || cout1 !== 1'b1 || out_valid1 !== 1'b0) begin
                errors++;
                $display("FAIL hold cyc%0d got sum=%h cout=%b ov=%b want sum=2 cout=1 ov=0", c, sum1, cout1, out_valid1);
            end
        end
    endtask

    task automatic test_reset_mid();
        a1 = 4'd8; b1 = 4'd7; cin1 = 1'b0; in_valid1 = 1'b1;
        tick();
        checks++;
        if (sum1 !== 4'd5 || cout1 !== 1'b1 || out_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL midstream_pre got sum=%h cout=%b ov=%b want 5 1 1", sum1, cout1, out_valid1);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (sum1 !== 4'd0 || cout1 !== 1'b0 || out_valid1 !== 1'b0) begin
            errors++;
            $display("FAIL midstream_rst got sum=%h cout=%b ov=%b want 0 0 0", sum1, cout1, out_valid1);
        end
        rst_n = 1'b1; a1 = 4'd4; b1 = 4'd4; cin1 = 1'b1;
        tick();
        checks++;
        if (sum1 !== 4'd9 || cout1 !== 1'b0 || out_valid1 !== 1'b1) begin
            errors++;
            $display("FAIL midstream_resume got sum=%h cout=%b ov=%b want 9 0 1", sum1, cout1, out_valid1);
        end
        in_valid1 = 1'b0;
        tick();
    endtask

`ifdef BCD_ADDER_ERR_EN
    task automatic test_err();
        a1 = 4'hA; b1 = 4'h1; cin1 = 1'b0; in_valid1 = 1'b1;
        tick();
        checks++;
        if (err1 !== 1'b1 || sum1 !== 4'd1 || cout1 !== 1'b1) begin
            errors++;
            $display("FAIL err_set got err=%b sum=%h cout=%b want 1 1 1", err1, sum1, cout1);
        end
        in_valid1 = 1'b0;
        tick();
        checks++;
        if (err1 !== 1'b1) begin
            errors++;
            $display("FAIL err_hold got %b want 1", err1);
        end
        a1 = 4'h3; b1 = 4'h4; in_valid1 = 1'b1;
        tick();
        checks++;
        if (err1 !== 1'b0 || sum1 !== 4'd7 || cout1 !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got err=%b sum=%h cout=%b want 0 7 0", err1, sum1, cout1);
        end
        a4 = 16'h12B4; b4 = 16'h0000; cin4 = 1'b0; in_valid4 = 1'b1;
        tick();
        checks++;
        if (err4 !== 1'b1 || sum4 !== 16'h1314) begin
            errors++;
            $display("FAIL err_dig4 got err=%b sum=%h want 1 1314", err4, sum4);
        end
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst_n = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        test_reset();
        test_single();
        test_boundary();
        test_ripple();
        test_back_to_back();
        test_hold();
        test_reset_mid();
`ifdef BCD_ADDER_ERR_EN
        test_err();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
